// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// State and grant encodings plus the read-lane select helper.
package mem_arb_pkg;

  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    ACK    = 2'd3
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  // Fetch word lane inside a double-word, chosen by byte address bit 2.
  function automatic logic [31:0] pick_half(
    input logic        hi,
    input logic [63:0] dw
  );
    return hi ? dw[63:32] : dw[31:0];
  endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// Saturating wait counter for the arbiter's memory transaction.
// Flags expiry once the count reaches TIMEOUT-1.
module arb_wait_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between fetch and data requesters.
// One transaction in flight, alternating grant, sticky timeout flag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 29,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [29:0]       i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic [63:0]       d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  state_e            state_q, state_d;
  grant_e            last_q, last_d;
  logic              hi_q, hi_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [63:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [63:0]       d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;

  logic busy;
  logic expire;
  logic gnt_i;
  logic gnt_d;
  logic done;

  assign busy  = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign done  = busy && (mem_ready || expire);

  // Fetch loses only when data is also pending and fetch won last time.
  assign gnt_i = i_req && !(d_req && (last_q == GNT_I));
  assign gnt_d = d_req && !gnt_i;

  arb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!busy || done),
    .en     (busy),
    .expire (expire)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    hi_d        = hi_q;
    mem_req_d   = mem_req_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          gnt_i: begin
            state_d     = BUSY_I;
            last_d      = GNT_I;
            hi_d        = i_addr[0];
            mem_req_d   = 1'b1;
            mem_wen_d   = 1'b0;
            mem_addr_d  = ADDR_W'(i_addr[29:1]);
            mem_wdata_d = '0;
          end
          gnt_d: begin
            state_d     = BUSY_D;
            last_d      = GNT_D;
            hi_d        = 1'b0;
            mem_req_d   = 1'b1;
            mem_wen_d   = d_wen;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end
          default: ;
        endcase
      end
      BUSY_I, BUSY_D: begin
        if (done) begin
          if (state_q == BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_ready ? pick_half(hi_q, mem_rdata) : '0;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_ready) begin
              d_rdata_d = '0;
            end else if (!mem_wen_q) begin
              d_rdata_d = mem_rdata;
            end
          end
          if (!mem_ready) begin
            err_d = 1'b1;
          end
          mem_req_d   = 1'b0;
          mem_wen_d   = 1'b0;
          mem_wdata_d = '0;
          state_d     = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= GNT_D;
      hi_q        <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      hi_q        <= hi_d;
      mem_req_q   <= mem_req_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus random bench for mem_port_arbiter.
// A shadow memory and grant model predict every port and ack value.
module tb_mem_port_arbiter;

  localparam int AW = 29;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [29:0]   i_addr;
  logic [31:0]   i_rdata;
  logic          i_ack;
  logic          d_req;
  logic          d_wen;
  logic [AW-1:0] d_addr;
  logic [63:0]   d_wdata;
  logic [63:0]   d_rdata;
  logic          d_ack;
  logic          mem_req;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata;
  logic          mem_ready;
  logic          err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W  (AW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .d_req     (d_req),
    .d_wen     (d_wen),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_req   (mem_req),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .err       (err)
  );

  int errors = 0;
  int checks = 0;

  logic [63:0] shadow [logic [AW-1:0]];
  logic [31:0] exp_i;
  logic [63:0] exp_d;
  bit          exp_err;
  bit          last_d;
  bit          after_ack;

  function automatic logic [63:0] mem_at(input logic [AW-1:0] a);
    if (shadow.exists(a)) return shadow[a];
    return (64'(a) * 64'h0101_0101_0101_0101) ^ 64'h5A5A_0F0F_F0F0_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    step(n);
    after_ack = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {mem_req, mem_wen, i_ack, d_ack, err}, '0);
    chk({tag, "_addr"}, 64'(mem_addr), '0);
    chk({tag, "_wdata"}, mem_wdata, '0);
    chk({tag, "_irdata"}, 64'(i_rdata), '0);
    chk({tag, "_drdata"}, d_rdata, '0);
  endtask

  // Serve the next grant predicted by the model: latency, fields,
  // memory response, ack and returned data.
  task automatic serve(input int lat, input bit scramble,
                       input bit tmo, input bit keep);
    bit            gi;
    bit            hi;
    bit            ewen;
    int            w;
    logic [AW-1:0] ea;
    logic [63:0]   ewd;
    logic [63:0]   rd;
    gi = (i_req && d_req) ? last_d : i_req;
    last_d = !gi;
    if (gi) begin
      ea = i_addr / 2; hi = i_addr[0]; ewen = 1'b0; ewd = '0;
    end else begin
      ea = d_addr; hi = 1'b0; ewen = d_wen; ewd = d_wdata;
    end
    w = 0;
    do begin
      step();
      w++;
    end while (!mem_req && w < 6);
    chk("grant_latency", 64'(w), after_ack ? 64'd2 : 64'd1);
    chk("mem_addr", 64'(mem_addr), 64'(ea));
    chk("mem_wen", 64'(mem_wen), 64'(ewen));
    chk("mem_wdata", mem_wdata, ewd);
    if (scramble) begin
      d_addr = ~d_addr; d_wdata = ~d_wdata; i_addr = ~i_addr;
    end
    rd = {$urandom, $urandom};
    if (tmo) begin
      w = 1;
      while (w < 20) begin
        step();
        if (!mem_req) break;
        w++;
      end
      chk("timeout_len", 64'(w), 64'(TO));
    end else begin
      for (int k = 0; k < lat; k++) begin
        chk("busy_hold", 64'({mem_req, i_ack, d_ack}), 64'(3'b100));
        chk("busy_addr", 64'(mem_addr), 64'(ea));
        step();
      end
      chk("busy_hold", 64'({mem_req, i_ack, d_ack}), 64'(3'b100));
      if (gi || !ewen) rd = mem_at(ea);
      mem_ready = 1'b1;
      mem_rdata = rd;
      step();
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom};
    end
    if (tmo) begin
      if (gi) exp_i = '0;
      else exp_d = '0;
      exp_err = 1'b1;
    end else if (gi) begin
      exp_i = hi ? rd[63:32] : rd[31:0];
    end else if (!ewen) begin
      exp_d = rd;
    end else begin
      shadow[ea] = ewd;
    end
    chk("i_ack", 64'(i_ack), 64'(gi));
    chk("d_ack", 64'(d_ack), 64'(!gi));
    chk("i_rdata", 64'(i_rdata), 64'(exp_i));
    chk("d_rdata", d_rdata, exp_d);
    chk("ack_no_issue", 64'({mem_req, mem_wen}), '0);
    chk("err", 64'(err), 64'(exp_err));
    if (scramble) begin
      d_addr = ~d_addr; d_wdata = ~d_wdata; i_addr = ~i_addr;
    end
    if (!keep) begin
      if (gi) i_req = 1'b0;
      else d_req = 1'b0;
    end
    after_ack = 1'b1;
  endtask

  task automatic model_reset();
    exp_i = '0; exp_d = '0; exp_err = 1'b0;
    last_d = 1'b1; after_ack = 1'b0;
  endtask

  initial begin
    int mode;
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0;
    d_wen = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    model_reset();
    step(2);
    chk_all_zero("reset");
    rst = 1'b0;

    // Odd fetch selects the upper lane.
    shadow[29'h2] = 64'hAAAA_BBBB_CCCC_DDDD;
    i_addr = 30'h5; i_req = 1'b1;
    serve(0, 0, 0, 0);
    chk("fetch_upper", 64'(i_rdata), 64'h0000_0000_AAAA_BBBB);

    // Write held for 3 wait cycles with requester fields scrambled.
    d_wen = 1'b1; d_addr = 29'h10; d_wdata = 64'h1234_5678_9ABC_DEF0;
    d_req = 1'b1;
    serve(3, 1, 0, 0);

    d_wen = 1'b0; d_addr = 29'h10; d_req = 1'b1;
    serve(1, 0, 0, 0);
    chk("write_readback", d_rdata, 64'h1234_5678_9ABC_DEF0);

    // Both held continuously: I, D, I, D.
    i_addr = 30'h8; d_addr = 29'h3; d_wen = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("alt_expect", 64'(last_d), 64'(k % 2 == 0));
      serve(k, 0, 0, k < 3);
    end
    i_req = 1'b0;

    for (int it = 0; it < 30; it++) begin
      mode = $urandom_range(0, 2);
      i_addr = 30'($urandom_range(0, 31));
      d_addr = AW'($urandom_range(0, 15));
      d_wen = 1'($urandom_range(0, 1));
      d_wdata = {$urandom, $urandom};
      i_req = (mode != 1);
      d_req = (mode != 0);
      serve($urandom_range(0, 5), 0, 0, 0);
      if (mode == 2) serve($urandom_range(0, 5), 0, 0, 0);
    end

    // Stray mem_ready with nothing in flight.
    idle(2);
    mem_ready = 1'b1;
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("spurious_ready", 64'({mem_req, i_ack, d_ack}), '0);
    end
    mem_ready = 1'b0;
    idle(1);

    d_wen = 1'b0; d_addr = 29'h3; d_req = 1'b1;
    serve(0, 0, 1, 0);
    idle(10);
    chk("err_sticky", 64'({err, i_ack, d_ack, mem_req}), 64'(4'b1000));

    // Reset during the second busy cycle of a data read.
    d_wen = 1'b0; d_addr = 29'h5; d_req = 1'b1;
    step(2);
    chk("pre_reset_busy", 64'(mem_req), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("mid_reset");
    model_reset();
    i_addr = 30'h6; i_req = 1'b1; d_req = 1'b1;
    serve(2, 0, 0, 0);
    serve(0, 0, 0, 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
